// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: frame widths, bit-counter limits and FSM states shared by spi_frame_receiver.
package spi_frame_pkg;
    localparam int FRAME_BITS = 16;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_SAT = 5'd17;
    localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
    localparam logic [CNT_W-1:0] FLUSH_CYC = 5'd3;
    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} spi_frame_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit, reset value selectable.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= {2{RST_VAL}};
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver: synchronizes SPI pins and deserializes 16-bit MSB-first frames.
// Define SPI_FRAME_ERRCNT_EN to build the saturating malformed-frame counter on err_count.
module spi_frame_receiver
    import spi_frame_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic              frame_valid,
    output logic              frame_rw,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_err,
    output logic [7:0]        err_count
);
    logic sclk_s, copi_s, ncs_s, sclk_q, copi_q, ncs_q;
    logic sclk_rise, ncs_rise, ncs_fall;
    spi_frame_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [FRAME_BITS-1:0] shreg, shreg_n;
    logic valid_n, err_n;

    sync_2ff #(.RST_VAL(1'b0)) u_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
    sync_2ff #(.RST_VAL(1'b0)) u_copi (.clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s));
    sync_2ff #(.RST_VAL(1'b1)) u_ncs  (.clk(clk), .rst_n(rst_n), .d(ncs),  .q(ncs_s));

    // Edges are registered; copi_q is delayed alongside so it lines up with sclk_rise.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {sclk_q, copi_q, ncs_q} <= 3'b001;
            {sclk_rise, ncs_rise, ncs_fall} <= 3'b000;
        end else begin
            {sclk_q, copi_q, ncs_q} <= {sclk_s, copi_s, ncs_s};
            sclk_rise <= sclk_s & ~sclk_q;
            ncs_rise  <= ncs_s & ~ncs_q;
            ncs_fall  <= ~ncs_s & ncs_q;
        end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            // cnt doubles as a flush timer so ncs_q reflects the pin, not the reset value.
            WAIT_IDLE: begin
                cnt_n = (cnt == FLUSH_CYC) ? cnt : cnt + 5'd1;
                if (cnt == FLUSH_CYC && ncs_q) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            IDLE: if (ncs_fall) begin
                state_n = SHIFT;
                cnt_n   = '0;
                shreg_n = '0;
            end
            SHIFT: if (ncs_rise) begin
                state_n = IDLE;
                valid_n = cnt == CNT_FULL;
                err_n   = cnt != '0 && cnt != CNT_FULL;
            end else if (sclk_rise) begin
                shreg_n = {shreg[FRAME_BITS-2:0], copi_q};
                cnt_n   = (cnt == CNT_SAT) ? cnt : cnt + 5'd1;
            end
            default: state_n = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= WAIT_IDLE;
            cnt         <= '0;
            shreg       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            {frame_rw, frame_addr, frame_data} <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            shreg       <= shreg_n;
            frame_valid <= valid_n;
            frame_err   <= err_n;
            if (valid_n) {frame_rw, frame_addr, frame_data} <= shreg;
        end

`ifdef SPI_FRAME_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err_count <= '0;
        else if (err_n && err_count != 8'hFF) err_count <= err_count + 8'd1;
`else
    assign err_count = '0;
`endif
endmodule
